// File: rtl/jtframe_rr_pick.sv
// Round-robin picker: first asserted request after 'last', wrapping modulo NREQ.
// Purely combinational so any arbiter can register the result as it sees fit.
module jtframe_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic            valid,
  output logic [IDW-1:0]  idx
);

  // Walk from the farthest candidate to the nearest so the nearest match wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = int'(NREQ); i >= 1; i--) begin
      int j;
      j = (int'(last) + i) % int'(NREQ);
      if (req[j]) begin
        valid = 1'b1;
        idx   = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/jtframe_68kdma_arb.sv
// Shares the 68000 bus among DMA devices: one combined bus request upstream,
// round-robin one-hot grants downstream with optional hold-time preemption.
module jtframe_68kdma_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned HOLDW   = 8,
  parameter int unsigned MAXHOLD = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic [NREQ-1:0] req,
  input  logic            bus_owned,
  output logic            bus_req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            busy,
  output logic            preempt
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitBus,
    StGrant,
    StSwitch,
    StRelease
  } state_e;

  localparam logic [HOLDW-1:0] CntMax  = '1;
  localparam logic [HOLDW-1:0] HoldLim = HOLDW'((MAXHOLD == 0) ? 0 : MAXHOLD - 1);
  localparam logic [IDW-1:0]   LastRst = IDW'(NREQ - 1);

  state_e            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0]    gnt_id_q, gnt_id_d;
  logic [IDW-1:0]    last_q, last_d;
  logic [HOLDW-1:0]  cnt_q, cnt_d;
  logic              preempt_q, preempt_d;

  logic              pick_valid;
  logic [IDW-1:0]    pick_idx;
  logic              others;
  logic              timeout;

  jtframe_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign others  = |(req & ~gnt_q);
  assign timeout = (MAXHOLD != 0) && (cnt_q >= HoldLim);

  always_comb begin
    state_d   = state_q;
    bus_req_d = bus_req_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    preempt_d = preempt_q;
    if (cen) begin
      preempt_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            bus_req_d = 1'b1;
            state_d   = StWaitBus;
          end
        end
        StWaitBus, StSwitch: begin
          // Losing the bus mid-transfer is a protocol fault: drop everything.
          if (state_q == StSwitch && !bus_owned) begin
            bus_req_d = 1'b0;
            state_d   = StIdle;
          end else if (pick_valid && (bus_owned || state_q == StSwitch)) begin
            gnt_d    = NREQ'(1) << pick_idx;
            gnt_id_d = pick_idx;
            last_d   = pick_idx;
            cnt_d    = '0;
            state_d  = StGrant;
          end else if (!pick_valid) begin
            bus_req_d = 1'b0;
            state_d   = StRelease;
          end
        end
        StGrant: begin
          cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
          if (!bus_owned) begin
            gnt_d     = '0;
            bus_req_d = 1'b0;
            state_d   = StIdle;
          end else if (!req[gnt_id_q]) begin
            gnt_d   = '0;
            state_d = StSwitch;
          end else if (timeout && others) begin
            gnt_d     = '0;
            preempt_d = 1'b1;
            state_d   = StSwitch;
          end
        end
        StRelease: begin
          bus_req_d = 1'b0;
          if (!bus_owned) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bus_req_q <= 1'b0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      last_q    <= LastRst;
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_req_q <= bus_req_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign bus_req = bus_req_q;
  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = (state_q != StIdle);
  assign preempt = preempt_q;

endmodule

// File: tb/tb_jtframe_68kdma_arb.sv
// Directed bench for jtframe_68kdma_arb: a vector table for the basic handshake
// plus scripted sequences for rotation, preemption, saturation, reset and cen.
module tb_jtframe_68kdma_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       cen;
  logic [3:0] req;
  logic       bus_owned;

  logic       bus_req, busy, preempt;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       bus_req0, busy0, preempt0;
  logic [3:0] gnt0;
  logic [1:0] gnt_id0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jtframe_68kdma_arb #(
    .NREQ    (4),
    .IDW     (2),
    .HOLDW   (8),
    .MAXHOLD (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .req       (req),
    .bus_owned (bus_owned),
    .bus_req   (bus_req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .preempt   (preempt)
  );

  jtframe_68kdma_arb #(
    .NREQ    (4),
    .IDW     (2),
    .HOLDW   (8),
    .MAXHOLD (0)
  ) dut0 (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .req       (req),
    .bus_owned (bus_owned),
    .bus_req   (bus_req0),
    .gnt       (gnt0),
    .gnt_id    (gnt_id0),
    .busy      (busy0),
    .preempt   (preempt0)
  );

  typedef struct {
    logic [3:0] req;
    logic       bo;
    logic [3:0] gnt;
    logic       br;
    logic       busy;
    logic       pre;
    logic [1:0] id;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // Bring a request set up to its first grant: one tick into WAIT_BUS, then bus owned.
  task automatic start_grant(input logic [3:0] r);
    req       = r;
    bus_owned = 1'b0;
    tick();
    bus_owned = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; req = '0; bus_owned = 1'b0;
    #3;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_bus_req", 32'(bus_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_gnt_id", 32'(gnt_id), 0);
    check("rst_preempt", 32'(preempt), 0);
    check("rst_cnt", 32'(dut.cnt_q), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    //            req    bo    gnt    br    busy  pre   id
    vecs[0]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[1]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[2]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[3]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[4]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[5]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[8]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[9]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[10] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 2'd2};
    vecs[11] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 2'd2};
    vecs[12] = '{4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2};
    vecs[13] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2};

    for (int i = 0; i < 14; i++) begin
      req       = vecs[i].req;
      bus_owned = vecs[i].bo;
      tick();
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("vec%0d_bus_req", i), 32'(bus_req), 32'(vecs[i].br));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_preempt", i), 32'(preempt), 32'(vecs[i].pre));
      check($sformatf("vec%0d_gnt_id", i), 32'(gnt_id), 32'(vecs[i].id));
    end

    // Round-robin: each grantee holds 5 ticks, drops for one tick, re-raises.
    do_reset();
    start_grant(4'b1111);
    for (int k = 0; k < 5; k++) begin
      int dev;
      dev = k % 4;
      check($sformatf("rr%0d_gnt_s0", k), 32'(gnt), 32'(4'b0001 << dev));
      check($sformatf("rr%0d_id", k), 32'(gnt_id), 32'(dev));
      for (int s = 1; s < 5; s++) begin
        tick();
        check($sformatf("rr%0d_gnt_s%0d", k, s), 32'(gnt), 32'(4'b0001 << dev));
      end
      if (k < 4) begin
        req[dev] = 1'b0;
        tick();
        check($sformatf("rr%0d_dead", k), 32'(gnt), 0);
        req[dev] = 1'b1;
        tick();
      end
    end

    // Preemption with MAXHOLD=8; dut0 (MAXHOLD=0) must never let go.
    do_reset();
    start_grant(4'b0011);
    for (int p = 0; p < 2; p++) begin
      logic [3:0] g;
      g = (p == 0) ? 4'b0001 : 4'b0010;
      for (int s = 0; s < 8; s++) begin
        if (s > 0) tick();
        check($sformatf("pre%0d_gnt_s%0d", p, s), 32'(gnt), 32'(g));
        check($sformatf("pre%0d_nopulse_s%0d", p, s), 32'(preempt), 0);
        check($sformatf("pre%0d_hold0_s%0d", p, s), 32'(gnt0), 32'(4'b0001));
      end
      tick();
      check($sformatf("pre%0d_dead", p), 32'(gnt), 0);
      check($sformatf("pre%0d_pulse", p), 32'(preempt), 1);
      check($sformatf("pre%0d_hold0_dead", p), 32'(gnt0), 32'(4'b0001));
      tick();
    end
    check("pre_back_to_0", 32'(gnt), 32'(4'b0001));
    check("pre_pulse_cleared", 32'(preempt), 0);
    check("pre_hold0_end", 32'(gnt0), 32'(4'b0001));
    check("pre_hold0_nopulse", 32'(preempt0), 0);

    // Lone holder never preempted; counter saturates at 255.
    do_reset();
    start_grant(4'b0100);
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (preempt !== 1'b0 || gnt !== 4'b0100)
        check($sformatf("lone_t%0d_gnt_pre", n), {27'd0, preempt, gnt}, 32'(4'b0100));
      if (n == 254 || n == 255 || n == 256 || n == 300)
        check($sformatf("lone_cnt_t%0d", n), 32'(dut.cnt_q), (n < 255) ? n : 255);
    end
    check("lone_gnt_end", 32'(gnt), 32'(4'b0100));

    // Async reset mid-grant: outputs clear before any clock edge.
    do_reset();
    start_grant(4'b0010);
    check("ar_pre_gnt", 32'(gnt), 32'(4'b0010));
    check("ar_pre_id", 32'(gnt_id), 1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_gnt", 32'(gnt), 0);
    check("ar_id", 32'(gnt_id), 0);
    check("ar_bus_req", 32'(bus_req), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_preempt", 32'(preempt), 0);
    rst = 1'b0;
    start_grant(4'b1010);
    check("ar_after_gnt", 32'(gnt), 32'(4'b0010));
    check("ar_after_id", 32'(gnt_id), 1);

    // Cen low freezes everything mid-grant.
    tick();
    tick();
    check("cen_cnt_before", 32'(dut.cnt_q), 2);
    cen = 1'b0;
    req = 4'b0000;
    for (int c = 0; c < 10; c++) tick();
    check("cen_cnt_frozen", 32'(dut.cnt_q), 2);
    check("cen_gnt_frozen", 32'(gnt), 32'(4'b0010));
    check("cen_busy_frozen", 32'(busy), 1);
    req = 4'b1010;
    cen = 1'b1;
    tick();
    check("cen_cnt_resume", 32'(dut.cnt_q), 3);

    // Bus lost during grant: protocol fault, back to idle without a pulse.
    bus_owned = 1'b0;
    tick();
    check("fault_gnt", 32'(gnt), 0);
    check("fault_bus_req", 32'(bus_req), 0);
    check("fault_busy", 32'(busy), 0);
    check("fault_preempt", 32'(preempt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
